// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: returns |(x,y)| or atan2(y,x) for Q2.30 operands.
// Multi-cycle custom-instruction handshake: start in, done pulse out after ITER+1 enabled cycles.
module cordic_vector #(
  parameter int ITER = 20,
  parameter int W    = 34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic        n,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ROT  = 2'd1;
  localparam logic [1:0] COMP = 2'd2;

  localparam int          PW      = W + 33;
  localparam logic [31:0] K_GAIN  = 32'h26DD3B6A;
  localparam logic signed [W-1:0] HALF_PI = W'(32'sh6487ED51);

  // atan(2^-i) in Q2.30; shared with the rotation-mode core
  localparam logic [31:0] ATAN [30] = '{
    32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7, 32'h03FEAB77,
    32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55, 32'h003FFFEB, 32'h001FFFFD,
    32'h00100000, 32'h00080000, 32'h00040000, 32'h00020000, 32'h00010000,
    32'h00008000, 32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
    32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040,
    32'h00000020, 32'h00000010, 32'h00000008, 32'h00000004, 32'h00000002
  };

  logic [1:0]          state;
  logic [4:0]          cnt;
  logic signed [W-1:0] x, y, z;
  logic                n_q, zero_q;

  logic signed [W-1:0] ax, ay, x_sh, y_sh, atan_ext;
  logic signed [PW-1:0] x_ext, k_ext, prod;
  logic                ovf;
  logic [31:0]         mag, ang;
  logic                unused_bits;

  always_comb begin
    ax       = {{(W-32){dataa[31]}}, dataa};
    ay       = {{(W-32){datab[31]}}, datab};
    x_sh     = x >>> cnt;
    y_sh     = y >>> cnt;
    atan_ext = {{(W-32){1'b0}}, ATAN[cnt]};
  end

  // Gain compensation: mag = x * K >>> 30, clamped to the unsigned-valued Q2.30 range
  always_comb begin
    x_ext = PW'(x);
    k_ext = PW'(K_GAIN);
    prod  = x_ext * k_ext;
    ovf   = |prod[PW-2:61];
    if (prod[PW-1])  mag = 32'h0;
    else if (ovf)    mag = 32'h7FFFFFFF;
    else             mag = prod[61:30];
    ang = z[32:1];
  end

  assign unused_bits = ^{prod[29:0], z[W-1:33], z[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      n_q    <= 1'b0;
      zero_q <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_q    <= n;
            zero_q <= (dataa == 32'h0) && (datab == 32'h0);
            cnt    <= '0;
            if (!ax[W-1]) begin
              x <= ax;  y <= ay;  z <= '0;
            end else if (!ay[W-1]) begin
              x <= ay;  y <= -ax; z <= HALF_PI;
            end else begin
              x <= -ay; y <= ax;  z <= -HALF_PI;
            end
            state <= ROT;
          end
        end
        ROT: begin
          // NOTE: non-blocking updates make x and y both use the pre-iteration values.
          if (!y[W-1]) begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_ext;
          end else begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_ext;
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITER - 1)) state <= COMP;
        end
        COMP: begin
          if (zero_q)   result <= 32'h0;
          else if (n_q) result <= ang;
          else          result <= mag;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector: real-math reference model feeds a scoreboard
// queue at issue time; results are popped and checked when done pulses.
module tb_cordic_vector;

  logic        clk = 1'b0;
  logic        reset, clk_en, start, n, done;
  logic [31:0] dataa, datab, result;

  always #5 clk = ~clk;

  cordic_vector #(.ITER(20), .W(34)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .n      (n),
    .done   (done),
    .result (result)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          tol;
    int          lat;
  } sb_t;

  sb_t sb[$];
  int  total  = 0;
  int  passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                       input int tol);
    longint diff;
    diff = longint'($signed(obs)) - longint'($signed(exp));
    if (diff < 0) diff = -diff;
    total++;
    if (tol == 0) begin
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end else begin
      assert ((!$isunknown(obs) && diff <= longint'(tol)) === 1'b1) passed++;
      else $error("FAIL %s: observed %h expected %h +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Reference: ideal atan2 (Q3.29) or magnitude (Q2.30) from real arithmetic
  function automatic sb_t model(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic sel, input int lat);
    sb_t e;
    real xr, yr, v;
    e.tag = tag;
    e.lat = lat;
    xr = $itor($signed(a)) / 1073741824.0;
    yr = $itor($signed(b)) / 1073741824.0;
    if (a == 32'h0 && b == 32'h0) begin
      e.exp = 32'h0;
      e.tol = 0;
    end else if (sel) begin
      v = $atan2(yr, xr) * 536870912.0;
      e.exp = 32'($rtoi(v < 0.0 ? v - 0.5 : v + 0.5));
      e.tol = 2048;
    end else begin
      v = $sqrt(xr * xr + yr * yr) * 1073741824.0;
      if (v >= 2147483647.0) begin
        e.exp = 32'h7FFFFFFF;
        e.tol = 0;
      end else begin
        e.exp = 32'($rtoi(v + 0.5));
        e.tol = 4096;
      end
    end
    return e;
  endfunction

  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sel, input int exp_lat);
    @(negedge clk);
    dataa = a;
    datab = b;
    n     = sel;
    start = 1'b1;
    sb.push_back(model(tag, a, b, sel, exp_lat));
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = ~sel;
    dataa = $urandom;
    datab = $urandom;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sel, input int exp_lat, input int gap_at,
                       input int repulse_at, input bit hold);
    sb_t e;
    int  lat;
    issue(tag, a, b, sel, exp_lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      start = (lat == repulse_at);
      if (gap_at >= 0 && lat == gap_at)     clk_en = 1'b0;
      if (gap_at >= 0 && lat == gap_at + 4) clk_en = 1'b1;
    end
    start  = 1'b0;
    clk_en = 1'b1;
    e = sb.pop_front();
    check({e.tag, "_latency"}, 32'(lat), 32'(e.lat), 0);
    check({e.tag, "_result"}, result, e.exp, e.tol);
    if (hold) begin
      clk_en = 1'b0;
      @(posedge clk);
      #1;
      check({e.tag, "_done_frozen"}, {31'b0, done}, 32'h1, 0);
      clk_en = 1'b1;
    end
    @(posedge clk);
    #1;
    check({e.tag, "_done_pulse"}, {31'b0, done}, 32'h0, 0);
    check({e.tag, "_result_hold"}, result, e.exp, e.tol);
  endtask

  initial begin
    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    n      = 1'b0;
    dataa  = '0;
    datab  = '0;
    #12;
    check("reset_done", {31'b0, done}, 32'h0, 0);
    check("reset_result", result, 32'h0, 0);
    @(negedge clk);
    reset = 1'b0;

    do_op("mag_x_axis",   32'h20000000, 32'h00000000, 1'b0, 21, -1, -1, 1'b1);
    do_op("ang_x_axis",   32'h20000000, 32'h00000000, 1'b1, 21, -1, -1, 1'b0);
    do_op("mag_diag",     32'h20000000, 32'h20000000, 1'b0, 21, -1, -1, 1'b0);
    do_op("ang_diag",     32'h20000000, 32'h20000000, 1'b1, 21, -1, -1, 1'b0);
    do_op("ang_pi",       32'hE0000000, 32'h00000000, 1'b1, 21, -1, -1, 1'b0);
    do_op("ang_neg_half", 32'h00000000, 32'hE0000000, 1'b1, 21, -1, -1, 1'b0);
    do_op("ang_q3",       32'hE0000000, 32'hE0000000, 1'b1, 21, -1, -1, 1'b0);
    do_op("ang_q4",       32'h20000000, 32'hE0000000, 1'b1, 21, -1, -1, 1'b0);
    do_op("mag_q2",       32'hE0000000, 32'h30000000, 1'b0, 21, -1, -1, 1'b0);
    do_op("ang_min_x",    32'h80000000, 32'h00000000, 1'b1, 21, -1, -1, 1'b0);
    do_op("ang_min_xy",   32'h80000000, 32'h80000000, 1'b1, 21, -1, -1, 1'b0);
    do_op("zero_mag",     32'h00000000, 32'h00000000, 1'b0, 21, -1, -1, 1'b0);
    do_op("mag_sat",      32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 21, -1, -1, 1'b0);
    do_op("zero_ang",     32'h00000000, 32'h00000000, 1'b1, 21, -1, -1, 1'b0);
    do_op("mag_mixed",    32'h1A000000, 32'hD3000000, 1'b0, 21, -1, -1, 1'b0);
    do_op("restart_ign",  32'h20000000, 32'h20000000, 1'b1, 21, -1,  5, 1'b0);
    do_op("clk_en_gap",   32'h20000000, 32'h20000000, 1'b1, 25,  5, -1, 1'b0);

    // Reset in the middle of ROT discards the operation and clears outputs at once
    issue("aborted", 32'h20000000, 32'h00000000, 1'b0, 21);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset_mid_done", {31'b0, done}, 32'h0, 0);
    check("reset_mid_result", result, 32'h0, 0);
    sb.delete();
    #2;
    reset = 1'b0;
    do_op("after_reset", 32'h20000000, 32'h20000000, 1'b0, 21, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
